// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the decode-side hazard sources and the stage-register controls.
// Latency: none; this is wiring only, with no storage.
// Backpressure: pc_en and stage_en are the stall controls returned to fetch and the stage registers.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int REG_W      = 5,
    parameter int INSTR_W    = 32,
    parameter int CNT_W      = 16
);
    logic                  icache_miss;
    logic                  dcache_miss;
    logic [REG_W-1:0]      dec_regA;
    logic [REG_W-1:0]      dec_regB;
    logic                  dec_uses_regB;
    logic                  ex_mem_r_en;
    logic [REG_W-1:0]      ex_regD;
    logic                  branch_taken;
    logic                  multi_start;
    logic                  pc_en;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_flush;
    logic [INSTR_W-1:0]    inject_nop;
    logic                  injecting_nop;
    logic                  multi_busy;
    logic [CNT_W-1:0]      stall_cycles;

    // Pipeline side: raises hazards, consumes enables/flushes.
    modport master (
        output icache_miss, dcache_miss, dec_regA, dec_regB, dec_uses_regB,
               ex_mem_r_en, ex_regD, branch_taken, multi_start,
        input  pc_en, stage_en, stage_flush, inject_nop, injecting_nop,
               multi_busy, stall_cycles
    );

    // Controller side.
    modport slave (
        input  icache_miss, dcache_miss, dec_regA, dec_regB, dec_uses_regB,
               ex_mem_r_en, ex_regD, branch_taken, multi_start,
        output pc_en, stage_en, stage_flush, inject_nop, injecting_nop,
               multi_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline hazard control: the PC enable, stage enables and flushes, and NOP injection.
// Latency: enables and flushes are combinational from the state and inputs; stall_cycles is registered.
// Backpressure: a dcache miss freezes everything; multi-cycle ops, load-use and icache misses stall the front end.
module pipe_hazard_ctrl #(
    parameter int                 NUM_STAGES = 4,
    parameter int                 REG_W      = 5,
    parameter int                 INSTR_W    = 32,
    parameter logic [INSTR_W-1:0] NOP_WORD   = 32'h0000_0000,
    parameter int                 MULTI_LAT  = 4,
    parameter int                 CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CNT_BITS = $clog2(MULTI_LAT);
    // The start cycle counts as the first busy cycle, and the cnt==0 cycle as the last.
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(MULTI_LAT - 2);
    localparam logic [CNT_W-1:0]    STALL_MAX = '1;

    typedef enum logic {RUN, MULTI} state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]      stall_q, stall_d;

    logic                  load_use;
    logic                  busy;
    logic                  pc_en;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_flush;
    logic                  injecting_nop;

    assign load_use = hz.ex_mem_r_en && (hz.ex_regD != '0) &&
                      ((hz.ex_regD == hz.dec_regA) ||
                       (hz.dec_uses_regB && (hz.ex_regD == hz.dec_regB)));

    // The op is busy from the very cycle it enters EX, before the FSM has moved.
    assign busy = (state_q == MULTI) || ((state_q == RUN) && hz.multi_start);

    // Priority arbitration of the hazard sources; reset forces the pipeline to run freely.
    always_comb begin
        pc_en         = 1'b1;
        stage_en      = '1;
        stage_flush   = '0;
        injecting_nop = 1'b0;
        if (!reset) begin
            pc_en = 1'b1;
        end else if (hz.dcache_miss) begin
            pc_en    = 1'b0;
            stage_en = '0;
        end else if (busy) begin
            pc_en          = 1'b0;
            stage_en[0]    = 1'b0;
            stage_en[1]    = 1'b0;
            stage_flush[2] = 1'b1;
        end else if (hz.branch_taken) begin
            stage_flush[0] = 1'b1;
            stage_flush[1] = 1'b1;
        end else if (load_use) begin
            pc_en          = 1'b0;
            stage_en[0]    = 1'b0;
            stage_flush[1] = 1'b1;
        end else if (hz.icache_miss) begin
            pc_en          = 1'b0;
            stage_flush[0] = 1'b1;
            injecting_nop  = 1'b1;
        end
    end

    // Multi-cycle FSM next state; a dcache miss freezes both the state and the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!hz.dcache_miss) begin
            case (state_q)
                RUN: begin
                    if (hz.multi_start) begin
                        cnt_d   = CNT_INIT;
                        state_d = MULTI;
                    end
                end
                MULTI: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating count of front-end stall cycles.
    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State, latency counter and stall counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign hz.pc_en         = pc_en;
    assign hz.stage_en      = stage_en;
    assign hz.stage_flush   = stage_flush;
    assign hz.inject_nop    = NOP_WORD;
    assign hz.injecting_nop = injecting_nop;
    assign hz.multi_busy    = reset && busy;
    assign hz.stall_cycles  = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NUM_STAGES(4), .REG_W(5), .INSTR_W(32), .CNT_W(16)) h ();
    pipe_hazard_ctrl_if #(.NUM_STAGES(4), .REG_W(5), .INSTR_W(32), .CNT_W(2))  hs ();

    pipe_hazard_ctrl #(.NUM_STAGES(4), .REG_W(5), .INSTR_W(32), .NOP_WORD(32'h0000_0013),
                       .MULTI_LAT(4), .CNT_W(16))
        dut (.clk(clk), .reset(reset), .hz(h));

    pipe_hazard_ctrl #(.NUM_STAGES(4), .REG_W(5), .INSTR_W(32), .NOP_WORD(32'h0000_0013),
                       .MULTI_LAT(4), .CNT_W(2))
        dut_s (.clk(clk), .reset(reset), .hz(hs));

    assign hs.icache_miss   = h.icache_miss;
    assign hs.dcache_miss   = h.dcache_miss;
    assign hs.dec_regA      = h.dec_regA;
    assign hs.dec_regB      = h.dec_regB;
    assign hs.dec_uses_regB = h.dec_uses_regB;
    assign hs.ex_mem_r_en   = h.ex_mem_r_en;
    assign hs.ex_regD       = h.ex_regD;
    assign hs.branch_taken  = h.branch_taken;
    assign hs.multi_start   = h.multi_start;

    typedef struct {
        string      tag;
        logic       pc;
        logic [3:0] en;
        logic [3:0] fl;
        logic       inj;
        logic       busy;
        logic       chk_stall;
        int         stall;
        int         stall_s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_stall = 0;
    int   exp_sat = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, push the expectation, compare before the edge.
    task automatic step(input string tag, input logic rst, input logic ic, input logic dc,
                        input logic [4:0] ra, input logic [4:0] rb, input logic ub,
                        input logic mr, input logic [4:0] rd, input logic br, input logic ms,
                        input logic e_pc, input logic [3:0] e_en, input logic [3:0] e_fl,
                        input logic e_inj, input logic e_busy);
        exp_t e;
        exp_t o;
        @(negedge clk);
        reset = rst;
        h.icache_miss = ic;   h.dcache_miss = dc;
        h.dec_regA = ra;      h.dec_regB = rb;    h.dec_uses_regB = ub;
        h.ex_mem_r_en = mr;   h.ex_regD = rd;
        h.branch_taken = br;  h.multi_start = ms;
        e.tag = tag; e.pc = e_pc; e.en = e_en; e.fl = e_fl; e.inj = e_inj; e.busy = e_busy;
        e.chk_stall = rst; e.stall = exp_stall; e.stall_s = exp_sat;
        exp_q.push_back(e);
        #2;
        o = exp_q.pop_front();
        check_eq({o.tag, ".pc_en"}, {31'd0, h.pc_en}, {31'd0, o.pc});
        check_eq({o.tag, ".stage_en"}, {28'd0, h.stage_en}, {28'd0, o.en});
        check_eq({o.tag, ".stage_flush"}, {28'd0, h.stage_flush}, {28'd0, o.fl});
        check_eq({o.tag, ".injecting_nop"}, {31'd0, h.injecting_nop}, {31'd0, o.inj});
        check_eq({o.tag, ".multi_busy"}, {31'd0, h.multi_busy}, {31'd0, o.busy});
        if (o.chk_stall) begin
            check_eq({o.tag, ".stall_cycles"}, {16'd0, h.stall_cycles}, o.stall);
            check_eq({o.tag, ".stall_sat"}, {30'd0, hs.stall_cycles}, o.stall_s);
        end
        @(posedge clk);
        if (!rst) begin
            exp_stall = 0;
            exp_sat   = 0;
        end else if (!e_pc) begin
            exp_stall = exp_stall + 1;
            exp_sat   = (exp_sat == 3) ? 3 : exp_sat + 1;
        end
    endtask

    initial begin
        h.icache_miss = 0; h.dcache_miss = 0; h.dec_regA = 0; h.dec_regB = 0;
        h.dec_uses_regB = 0; h.ex_mem_r_en = 0; h.ex_regD = 0;
        h.branch_taken = 0; h.multi_start = 0;

        // Reset forces free-running outputs even with hazards asserted.
        step("rst0", 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 4'h0, 0, 0);
        step("rst1", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);
        step("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);
        check_eq("inject_nop", h.inject_nop, 32'h0000_0013);

        // Load-use on regA, then the r0 exception, then regB with and without use.
        step("lu_a",  1, 0, 0, 3, 0, 0, 1, 3, 0, 0, 0, 4'hE, 4'h2, 0, 0);
        step("lu_r0", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);
        step("lu_b",  1, 0, 0, 1, 7, 1, 1, 7, 0, 0, 0, 4'hE, 4'h2, 0, 0);
        step("lu_nb", 1, 0, 0, 1, 7, 0, 1, 7, 0, 0, 1, 4'hF, 4'h0, 0, 0);
        step("lu_ic", 1, 1, 0, 3, 0, 0, 1, 3, 0, 0, 0, 4'hE, 4'h2, 0, 0);

        // Multi-cycle op with a frozen cycle; branch and restart are ignored while busy.
        step("m_start",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hC, 4'h4, 0, 1);
        step("m_frozen", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 1);
        step("m_c2",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'hC, 4'h4, 0, 1);
        step("m_c1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hC, 4'h4, 0, 1);
        step("m_c0",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hC, 4'h4, 0, 1);
        step("m_done",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);

        // Branch beats load-use and icache miss; dcache miss beats branch.
        step("br_all", 1, 1, 0, 3, 0, 0, 1, 3, 1, 0, 1, 4'hF, 4'h3, 0, 0);
        step("dc_br",  1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 0, 0);

        // Icache miss bubbles, then a dcache miss on top.
        step("ic1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h1, 1, 0);
        step("ic2", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h1, 1, 0);
        step("ic3", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h1, 1, 0);
        step("ic_dc", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        step("idle2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);

        // Fresh counter, six icache stalls: the 2-bit counter saturates at 3.
        step("rst_s", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);
        for (int i = 0; i < 6; i++)
            step("sat", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h1, 1, 0);
        step("sat_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);

        // Reset in the middle of a multi-cycle op aborts it.
        step("mr_start", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hC, 4'h4, 0, 1);
        step("mr_busy",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hC, 4'h4, 0, 1);
        step("mr_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);
        step("mr_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the decode-stage control/stall logic: one block owns every pipeline-register enable and flush, the PC enable and NOP injection.
- Arbitrates data-cache stalls, instruction-cache stalls, load-use hazards, taken-branch flushes and multi-cycle execute ops (FSM plus latency counter).
- Keeps a saturating stall-cycle counter for performance debug.
- Sits beside the decoder and drives the fetch/decode/ALU/mem stage registers.

Parameters:
- NUM_STAGES, 4: number of pipeline registers. Index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3.. = later stages. Must be >= 3.
- REG_W, 5: register-specifier width.
- INSTR_W, 32: instruction width.
- NOP_WORD, 32'h0000_0000: encoding injected as a bubble.
- MULTI_LAT, 4: total stall cycles of a multi-cycle execute op. Must be >= 2.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge).
- icache_miss  in  1  fetch cannot deliver this cycle.
- dcache_miss  in  1  memory stage blocked this cycle.
- dec_regA  in  REG_W  source A of the instruction in decode.
- dec_regB  in  REG_W  source B of the instruction in decode.
- dec_uses_regB  in  1  decode instruction reads regB.
- ex_mem_r_en  in  1  instruction in EX is a load.
- ex_regD  in  REG_W  destination of the instruction in EX.
- branch_taken  in  1  branch/jump resolved taken in EX.
- multi_start  in  1  multi-cycle op entered EX this cycle (1-cycle pulse).
- pc_en  out  1  PC register load enable.
- stage_en  out  NUM_STAGES  pipeline register load enables.
- stage_flush  out  NUM_STAGES  load NOP instead of data (flush implies en=1).
- inject_nop  out  INSTR_W  constant NOP_WORD.
- injecting_nop  out  1  stage_flush[0] is set because of an icache miss.
- multi_busy  out  1  multi-cycle stall active.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en==0.

Behaviour:
- State register: RUN / MULTI. Counter cnt is $clog2(MULTI_LAT) bits wide. stall_cycles is registered. All other outputs are combinational from state and inputs.
- Reset (reset==0 at the edge): state=RUN, cnt=0, stall_cycles=0.
- While reset==0, outputs are forced to pc_en=1, stage_en=all 1, stage_flush=0, injecting_nop=0, multi_busy=0.
- multi_busy = (state==MULTI) | (state==RUN & multi_start).
- load_use = ex_mem_r_en & ex_regD!=0 & (ex_regD==dec_regA | (dec_uses_regB & ex_regD==dec_regB)).
- Priority, first match wins:
  1. dcache_miss: pc_en=0, stage_en=0, flush=0. FSM and cnt frozen.
  2. multi_busy: pc_en=0, en[0]=en[1]=0, flush[2]=1, en[3..]=1. branch_taken ignored.
  3. branch_taken: pc_en=1, flush[0]=flush[1]=1, all other en=1. Overrides load_use and icache_miss.
  4. load_use: pc_en=0, en[0]=0, flush[1]=1, all other en=1.
  5. icache_miss: pc_en=0, flush[0]=1, injecting_nop=1, all other en=1.
  6. none: pc_en=1, all en=1, flush=0.
- FSM transitions, taken only when dcache_miss==0:
  - RUN & multi_start: cnt <= MULTI_LAT-2, go to MULTI.
  - MULTI & cnt!=0: cnt <= cnt-1.
  - MULTI & cnt==0: go to RUN.
  - Net effect: exactly MULTI_LAT non-dcache-stalled busy cycles per op.
- multi_start while in MULTI is ignored (protocol violation; no restart).
- stall_cycles increments every cycle pc_en==0 and holds at 2^CNT_W-1.
- Reset mid-MULTI aborts the op: next cycle is RUN with all enables high.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> pc_en=1, stage_en=4'b1111, stage_flush=0, stall_cycles=0.
- ex_mem_r_en=1, ex_regD=3, dec_regA=3 for 1 cycle -> pc_en=0, stage_en[0]=0, stage_flush=4'b0010, stall_cycles=1. Same with ex_regD=0 -> no stall.
- multi_start pulse, MULTI_LAT=4, with dcache_miss=1 on the 2nd busy cycle -> multi_busy high for 5 cycles (4 counted + 1 frozen), stage_flush[2]=1 on the 4 counted cycles, 0 on the frozen cycle.
- branch_taken=1 with load_use=1 and icache_miss=1 together -> pc_en=1, stage_flush=4'b0011, injecting_nop=0.
- icache_miss=1 for 3 cycles -> injecting_nop=1, stage_flush[0]=1, pc_en=0 each cycle, stall_cycles=3. Then dcache_miss=1 -> stage_en=0.
- CNT_W=2, hold icache_miss for 6 cycles -> stall_cycles saturates at 3. Reset mid-MULTI -> multi_busy=0 the cycle after reset releases.
